// File: rtl/alu_chain_seq_if.sv
// Bus bundle for alu_chain_seq: control-side request/result and the byte-wide ALU link.
// Optional ALU_SEQ_CMP_EN adds the cmp_only request bit.
interface alu_chain_seq_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic                  ready;
  logic [1:0]            op_sel;
  logic [8*NBYTES-1:0]   opa;
  logic [8*NBYTES-1:0]   opb;
  logic [7:0]            flags_base;
  logic [7:0]            alu_a;
  logic [7:0]            alu_b;
  logic [3:0]            alu_op;
  logic [7:0]            alu_flags_in;
  logic [7:0]            alu_result;
  logic [7:0]            alu_flags_out;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  flag_c;
  logic                  flag_z;
  logic                  flag_n;
  logic                  flag_v;
`ifdef ALU_SEQ_CMP_EN
  logic                  cmp_only;
`endif

  modport master (
`ifdef ALU_SEQ_CMP_EN
    input  cmp_only,
`endif
    input  start, op_sel, opa, opb, flags_base, alu_result, alu_flags_out,
    output ready, alu_a, alu_b, alu_op, alu_flags_in, done, result,
           flag_c, flag_z, flag_n, flag_v
  );

  modport slave (
`ifdef ALU_SEQ_CMP_EN
    output cmp_only,
`endif
    output start, op_sel, opa, opb, flags_base, alu_result, alu_flags_out,
    input  ready, alu_a, alu_b, alu_op, alu_flags_in, done, result,
           flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/alu_chain_seq.sv
// Multi-byte ADD/SUB/AND/XOR sequencer driving an 8-bit combinational ALU, LSB first.
// Optional ALU_SEQ_CMP_EN: cmp_only with SUB updates flags but leaves result untouched.
module alu_chain_seq #(
  parameter int NBYTES = 4
) (
  input logic           clk,
  input logic           rst,
  alu_chain_seq_if.master bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} op_e;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0, ALU_SUB = 4'h1, ALU_ADC = 4'h2, ALU_SBC = 4'h3,
    ALU_AND  = 4'h4, ALU_XOR = 4'h6, ALU_PASS = 4'hD
  } alu_op_e;

  state_e          state_q, state_d;
  op_e             op_q;
  logic [W-1:0]    opa_q, opb_q, result_q;
  logic [IW-1:0]   idx_q;
  logic            cy_q, zacc_q, cmp_q;
  logic            flag_c_q, flag_z_q, flag_n_q, flag_v_q;
  logic [7:0]      a_byte, b_byte;
  logic            unused_flags;

  assign unused_flags = ^{bus.alu_flags_out[7:4], bus.flags_base[0]};

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (idx_q == IW'(k)) begin
        a_byte = opa_q[8*k +: 8];
        b_byte = opb_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.alu_op       = ALU_PASS;
    bus.alu_flags_in = {bus.flags_base[7:1], 1'b0};
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.alu_a        = a_byte;
        bus.alu_b        = b_byte;
        bus.alu_flags_in = {bus.flags_base[7:1], cy_q};
        case (op_q)
          OP_ADD:  bus.alu_op = (idx_q == '0) ? ALU_ADD : ALU_ADC;
          OP_SUB:  bus.alu_op = (idx_q == '0) ? ALU_SUB : ALU_SBC;
          OP_AND:  bus.alu_op = ALU_AND;
          default: bus.alu_op = ALU_XOR;
        endcase
        if (idx_q == LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_SEQ_CMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cmp_q <= 1'b0;
    else if (state_q == IDLE && bus.start)   cmp_q <= bus.cmp_only;
  end
`else
  assign cmp_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      zacc_q   <= 1'b1;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.start) begin
          op_q   <= op_e'(bus.op_sel);
          opa_q  <= bus.opa;
          opb_q  <= bus.opb;
          cy_q   <= 1'b0;
          zacc_q <= 1'b1;
          idx_q  <= '0;
        end
        RUN: begin
          // compare-only SUB keeps the previous result; flags still track the subtraction
          if (!(cmp_q && op_q == OP_SUB)) begin
            for (int unsigned k = 0; k < NBYTES; k++)
              if (idx_q == IW'(k)) result_q[8*k +: 8] <= bus.alu_result;
          end
          cy_q   <= bus.alu_flags_out[0];
          zacc_q <= zacc_q & bus.alu_flags_out[1];
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            flag_c_q <= bus.alu_flags_out[0];
            flag_n_q <= bus.alu_flags_out[2];
            flag_v_q <= bus.alu_flags_out[3];
            flag_z_q <= zacc_q & bus.alu_flags_out[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_n = flag_n_q;
  assign bus.flag_v = flag_v_q;
endmodule

// File: doc/alu_chain_seq.md
# alu_chain_seq

Multi-byte arithmetic sequencer that acts as the initiator driving the 8-bit combinational ALU. It accepts one NBYTES-wide operation through a start/ready handshake, then issues one ALU operation per cycle, least significant byte first. Between bytes it chains carry/borrow back into the ALU's flags input, then assembles the wide result and final flags. It sits between the control unit and the ALU and gives the 8-bit datapath 16/32-bit ADD/SUB/AND/XOR.

## Interface
Parameters:
- NBYTES, 4: operand width in bytes; legal range 2..8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- ready  out  1  high exactly when the FSM is in IDLE.
- op_sel  in  2  operation: 0 ADD, 1 SUB, 2 AND, 3 XOR.
- opa, opb  in  8*NBYTES  operands; latched on acceptance.
- flags_base  in  8  flag template; bits [7:1] are passed to the ALU unchanged.
- alu_a, alu_b  out  8  byte operands to the ALU.
- alu_op  out  4  ALU opcode.
- alu_flags_in  out  8  flags presented to the ALU.
- alu_result  in  8  ALU result byte.
- alu_flags_out  in  8  ALU flags: bit0 carry/borrow, bit1 zero, bit2 negative, bit3 overflow.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  8*NBYTES  wide result; held until the next acceptance.
- flag_c, flag_z, flag_n, flag_v  out  1  final carry/borrow, zero, negative and overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `ready=1`.
  - On `start&&ready`: latch opa, opb and op_sel; clear the carry chain register `cy`; set `zacc=1` and byte index `i=0`; go to RUN.
- RUN, byte i:
  - `alu_a=opa[8i+7:8i]` and `alu_b=opb[8i+7:8i]`.
  - `alu_flags_in={flags_base[7:1], cy}`.
  - alu_op by operation and byte:
    - ADD: 0x0 for i=0, 0x2 (ADC) otherwise.
    - SUB: 0x1 for i=0, 0x3 (SBC) otherwise.
    - AND: 0x4 for every byte.
    - XOR: 0x6 for every byte.
  - At each edge in RUN:
    - `result[8i+7:8i]<=alu_result`
    - `cy<=alu_flags_out[0]`
    - `zacc<=zacc&alu_flags_out[1]`
    - `i<=i+1`
  - When i=NBYTES-1:
    - `flag_c<=alu_flags_out[0]`
    - `flag_n<=alu_flags_out[2]`
    - `flag_v<=alu_flags_out[3]`
    - `flag_z<=zacc&alu_flags_out[1]`
    - go to DONE.
- DONE: `done=1` for one cycle, then return to IDLE unconditionally.
- Flags for AND/XOR:
  - The ALU clears carry, so flag_c=0 and flag_v=0.
  - Zero still accumulates across all bytes.
- Signed overflow comes from the top byte only. The per-byte overflow flags of lower bytes are ignored.
- When not in RUN, the ALU drive outputs are idle values:
  - alu_a=0 and alu_b=0.
  - alu_op=0xD (PASS).
  - alu_flags_in={flags_base[7:1],1'b0}.
- start while not ready is ignored; there is no queuing.
- op_sel/opa/opb changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, ready=1, done=0, result=0, all flag_* =0, cy=0, i=0. ALU drive outputs take their idle values.
- rst mid-operation: state returns to IDLE immediately and asynchronously. Partial results are discarded, result and flags are cleared, and no done pulse is produced.
- Latency:
  - Acceptance edge E0.
  - Byte k is presented in the cycle after E_k and captured at E_{k+1}.
  - done is high in the cycle following E_NBYTES.
  - ready returns 1 in the cycle after done.
  - A start may be accepted on the edge that ends the IDLE cycle.
- Throughput: one operation per NBYTES+2 cycles.
- The ALU path is combinational. alu_result must settle within the same cycle the byte is presented.

## Configuration
- ALU_SEQ_CMP_EN:
  - Defined: input port `cmp_only` (1 bit) is present and latched on acceptance. When cmp_only=1 with op_sel=SUB:
    - flags update as normal.
    - result is not written and keeps its prior value.
    - done still pulses.
  - Undefined: the port is absent and behaviour equals cmp_only=0.

## Test plan
- ADD, NBYTES=4: opa=0x000000FF, opb=0x00000001 -> alu_op sequence 0,2,2,2; result 0x00000100; c=0 z=0 n=0 v=0; done in cycle 4 after acceptance.
- ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000; c=1 z=1 n=0 v=0; alu_flags_in[0]=1 on bytes 1..3.
- SUB 0x80000000-0x00000001 -> alu_op 1,3,3,3; result 0x7FFFFFFF; v=1 n=0 c=0 z=0. SUB 0x0-0x1 -> 0xFFFFFFFF; c=1 n=1.
- XOR with opa=opb=0x12345678 and flags_base=0x30 -> alu_flags_in=0x30 every byte; result 0; z=1 c=0. Then AND 0xF0F0F0F0 with 0x0F0F0F0F -> 0, z=1.
- start pulsed during RUN -> ignored; single done. Assert rst while on byte 2 -> next cycle ready=1, result=0, no done. A fresh ADD afterwards completes correctly.
- With ALU_SEQ_CMP_EN: prior result 0xDEADBEEF, SUB cmp_only=1 with 5-5 -> result stays 0xDEADBEEF; z=1 c=0.
